// File: rtl/conv_result_writer.sv
// Rescales the convolution engine's Q.7 result stream to 8-bit pixels (round + saturate)
// and writes them sequentially into an output RAM, flagging frame completion.
module conv_result_writer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned FRAC_BITS = 7,
  parameter int unsigned FRAME_LEN = 36,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_st,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_din,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] sat_cnt,
  output logic              overrun
);

  localparam int unsigned R_W     = DATA_W + 1;
  localparam int unsigned RND     = 1 << (FRAC_BITS - 1);
  localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [ADDR_W-1:0] acc_cnt;
  logic              v1;
  logic [R_W-1:0]    r1;
  logic [R_W-1:0]    q;
  logic              sat;
  logic [PIX_W-1:0]  pix;

  // Stage-2 rescale: drop fractional bits, clamp anything above the pixel range.
  assign q   = r1 >> FRAC_BITS;
  assign sat = q > R_W'(PIX_MAX);
  assign pix = sat ? PIX_W'(PIX_MAX) : q[PIX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // in_st overrides everything, including a coincident beat.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (in_st) begin
      state_d = RECV;
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        RECV: begin
          accept = din_vld;
          if (din_vld && (acc_cnt == LAST_IDX)) state_d = DRAIN;
        end
        // Stage 2 empties on this edge whenever stage 1 is already empty.
        DRAIN: if (!v1) state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt    <= '0;
      v1         <= 1'b0;
      r1         <= '0;
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sat_cnt    <= '0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= (state_d == DONE) && (state_q != DONE);
      if (in_st) begin
        acc_cnt  <= '0;
        v1       <= 1'b0;
        ram_wr   <= 1'b0;
        ram_addr <= '0;
        sat_cnt  <= '0;
        overrun  <= 1'b0;
        busy     <= 1'b1;
      end else begin
        v1 <= accept;
        if (accept) begin
          acc_cnt <= acc_cnt + ADDR_W'(1);
          r1      <= {1'b0, din} + R_W'(RND);
        end
        ram_wr <= v1;
        if (v1) begin
          ram_din <= pix;
          if (sat && (sat_cnt != '1)) sat_cnt <= sat_cnt + ADDR_W'(1);
        end
        // Address advances after each write but parks on the last index.
        if (ram_wr && (ram_addr != LAST_IDX)) ram_addr <= ram_addr + ADDR_W'(1);
        if (din_vld && ((state_q == DRAIN) || (state_q == DONE))) overrun <= 1'b1;
        if (state_q == DONE) busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: vector table for rounding/saturation plus
// hand-written frame sequences (nominal, gapped, abort, overrun, async reset).
module tb_conv_result_writer;

  localparam int FRAME_LEN = 36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_st = 1'b0;
  logic        din_vld = 1'b0;
  logic [15:0] din = '0;
  logic        ram_wr;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_din;
  logic        busy;
  logic        frame_done;
  logic [5:0]  sat_cnt;
  logic        overrun;

  conv_result_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_st      (in_st),
    .din        (din),
    .din_vld    (din_vld),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .busy       (busy),
    .frame_done (frame_done),
    .sat_cnt    (sat_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  int wa[$];
  int wd[$];
  int wc[$];
  int done_cnt = 0;
  int done_cyc = -1;
  always @(negedge clk) begin
    if (ram_wr) begin
      wa.push_back(int'(ram_addr));
      wd.push_back(int'(ram_din));
      wc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  typedef struct {
    logic [15:0] din;
    int          pix;
    int          sat;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] bdin[40];
  int          bexp[40];
  int          bcyc[40];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_nominal();
    for (int k = 0; k < 40; k++) begin
      bdin[k] = 16'(k * 128);
      bexp[k] = k;
    end
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    wa.delete(); wd.delete(); wc.delete();
    in_st = 1'b1;
    @(posedge clk); #1;
    in_st = 1'b0;
  endtask

  task automatic drive_beats(input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      din     = bdin[i];
      din_vld = 1'b1;
      bcyc[i] = cyc;
      @(posedge clk); #1;
      din_vld = 1'b0;
      if (gapped) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      n_cmp  = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL frame_done_timeout: got no pulse, want one within 60 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int min_cyc, input int n, input int sat_exp, input int d0);
    int idx = 0;
    int last = -1;
    for (int j = 0; j < wa.size(); j++) begin
      if (wc[j] > min_cyc) begin
        if (idx < n) begin
          chk("wr_addr", 32'(wa[j]), 32'(idx));
          chk("wr_data", 32'(wd[j]), 32'(bexp[idx]));
          chk("wr_cycle", 32'(wc[j]), 32'(bcyc[idx] + 2));
        end
        last = wc[j];
        idx++;
      end
    end
    chk("wr_count", 32'(idx), 32'(n));
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("done_cycle", 32'(done_cyc), 32'(last + 1));
    chk("sat_cnt", 32'(sat_cnt), 32'(sat_exp));
    chk("busy_after", 32'(busy), 32'd0);
    chk("addr_hold", 32'(ram_addr), 32'(FRAME_LEN - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    int ab;
    int sat_exp;

    vecs[0]  = '{16'd63,    0,   0};
    vecs[1]  = '{16'd64,    1,   0};
    vecs[2]  = '{16'd191,   1,   0};
    vecs[3]  = '{16'd192,   2,   0};
    vecs[4]  = '{16'd32640, 255, 0};
    vecs[5]  = '{16'd32704, 255, 1};
    vecs[6]  = '{16'hFFFF,  255, 1};
    vecs[7]  = '{16'd0,     0,   0};
    vecs[8]  = '{16'd127,   1,   0};
    vecs[9]  = '{16'd128,   1,   0};
    vecs[10] = '{16'd16383, 128, 0};
    vecs[11] = '{16'd32767, 255, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    // Nominal back-to-back frame
    set_nominal();
    d0 = done_cnt;
    start_frame();
    chk("busy_start", 32'(busy), 32'd1);
    drive_beats(FRAME_LEN, 1'b0);
    wait_done(d0);
    check_frame(-1, FRAME_LEN, 0, d0);
    chk("overrun_nominal", 32'(overrun), 32'd0);

    // Rounding / saturation vector table at the head of a frame
    set_nominal();
    sat_exp = 0;
    for (int v = 0; v < 12; v++) begin
      bdin[v] = vecs[v].din;
      bexp[v] = vecs[v].pix;
      sat_exp += vecs[v].sat;
    end
    d0 = done_cnt;
    start_frame();
    drive_beats(FRAME_LEN, 1'b0);
    wait_done(d0);
    check_frame(-1, FRAME_LEN, sat_exp, d0);

    // Gapped stream
    set_nominal();
    d0 = done_cnt;
    start_frame();
    drive_beats(FRAME_LEN, 1'b1);
    wait_done(d0);
    check_frame(-1, FRAME_LEN, 0, d0);

    // Abort after 10 beats, then a fresh frame of din=256
    set_nominal();
    d0 = done_cnt;
    start_frame();
    drive_beats(10, 1'b0);
    in_st = 1'b1;
    ab = cyc;
    @(posedge clk); #1;
    in_st = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bdin[k] = 16'd256;
      bexp[k] = 2;
    end
    drive_beats(FRAME_LEN, 1'b0);
    wait_done(d0);
    check_frame(ab, FRAME_LEN, 0, d0);

    // Overrun: two beats beyond the frame
    set_nominal();
    d0 = done_cnt;
    start_frame();
    drive_beats(FRAME_LEN + 2, 1'b0);
    wait_done(d0);
    check_frame(-1, FRAME_LEN, 0, d0);
    chk("overrun_set", 32'(overrun), 32'd1);

    // Asynchronous reset mid-frame
    set_nominal();
    start_frame();
    chk("overrun_cleared", 32'(overrun), 32'd0);
    drive_beats(6, 1'b0);
    chk("mid_ram_wr", 32'(ram_wr), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_ram_wr", 32'(ram_wr), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_frame_done", 32'(frame_done), 32'd0);
    chk("async_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Recovery frame after reset
    set_nominal();
    d0 = done_cnt;
    start_frame();
    drive_beats(FRAME_LEN, 1'b0);
    wait_done(d0);
    check_frame(-1, FRAME_LEN, 0, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
